// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-and-add multiplier with valid/ready handshakes.
// Adds one partial product per clock, so a product takes WIDTH cycles.
// Signed operands are multiplied as magnitudes and the result sign is fixed
// up when the product is registered.
module seq_mult_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   OP_ONE   = WIDTH'(1);

    state_t               state;
    state_t               state_next;

    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;
    logic                 accept;
    logic                 handoff;

    // Operand magnitudes and the running partial-product sum.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        a_mag     = a;
        b_mag     = b;
        if (signed_mode && a[WIDTH-1]) a_mag = ~a + OP_ONE;
        if (signed_mode && b[WIDTH-1]) b_mag = ~b + OP_ONE;
        // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
        addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next  = acc + addend;
        last_iter = (cnt == LAST_CNT);
        accept    = in_valid && in_ready;
        handoff   = out_valid && out_ready;
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (handoff)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: capture operands, iterate, and register the signed-corrected product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_ONE;
                    // Negating a zero magnitude gives zero, so there is no negative zero.
                    if (last_iter) p <= neg ? -acc_next : acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised, iterative shift-and-add multiplier. Next generation of the team's fixed 3-bit combinational array multiplier.
- Generalised to WIDTH-bit operands, with a run-time unsigned/signed (two's complement) mode.
- Computes one partial-product step per clock. Valid/ready handshakes sit on both the operand and result sides.
- Sits between a producer of operand pairs and a consumer of full 2*WIDTH-bit products. Trades latency for area.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32. Product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b/signed_mode is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = treat a, b as two's complement; 0 = unsigned. Sampled with the operands.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product: two's complement if the captured signed_mode = 1, else unsigned.
- busy  output  1  high in CALC and DONE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator/counter/sign flag=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture:
    - mcand = |a|, mplier = |b|, when signed_mode=1 (magnitude as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), no overflow); else mcand = a, mplier = b.
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
    - acc = 0, cnt = 0.
  - Next state CALC. Without a handshake, stay in IDLE.
- CALC:
  - in_ready=0.
  - Each cycle: if mplier[0], acc += mcand << cnt (2*WIDTH-bit add, no carry out possible). Then mplier >>= 1, cnt += 1.
  - After exactly WIDTH iterations (cnt reaches WIDTH-1 on the final iteration), go to DONE and register p = neg ? -acc_final : acc_final (2*WIDTH-bit two's complement negate).
  - No early termination: latency is data-independent.
- DONE:
  - out_valid=1. p held stable while out_valid=1 and out_ready=0 (arbitrary backpressure).
  - On out_valid && out_ready, go to IDLE and clear out_valid next cycle. p keeps its last value.
  - in_ready stays 0 in DONE: no accept in the same cycle as result handoff.
- Latency: operand handshake at edge N gives out_valid=1 after edge N+WIDTH.
- Minimum initiation interval: WIDTH+2 cycles with out_ready held high.
- a, b and signed_mode changes during CALC/DONE are ignored.
- in_valid while busy: ignored, since in_ready=0. The producer must hold its data until the handshake.
- Zero operand: normal WIDTH-cycle latency, p=0. A signed zero result is never negative zero, because -0 = 0 in two's complement.
- Reset mid-operation (CALC or DONE): abort next edge. All outputs return to reset values; any pending product is lost with no out_valid pulse.
- rst has priority over every handshake in the same cycle.

Test Plan:
- WIDTH=8, unsigned, a=5, b=3, out_ready=1 -> out_valid rises exactly 8 cycles after the accept edge; p=16'h000F; in_ready returns to 1 the cycle after the output handshake.
- Unsigned a=255, b=255 -> p=16'hFE01 (65025). a=0, b=200 -> p=0 after the same 8-cycle latency.
- Signed a=8'hFD (-3), b=8'h07 -> p=16'hFFEB (-21). Signed a=8'h80, b=8'h80 (-128*-128) -> p=16'h4000. Signed a=8'h80, b=8'h01 -> p=16'hFF80.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> p and out_valid stay stable, in_ready=0 throughout. The next operand pair is accepted only after out_ready=1 completes the handoff.
- Reset mid-CALC: assert rst at iteration 4 of a=7, b=9 -> next cycle out_valid=0, p=0, in_ready=1. A new pair a=2, b=2 then yields p=16'h0004 with normal latency.
- Back-to-back random sweep (1000 pairs, mixed signed_mode, random in_valid/out_ready) -> every p matches a reference multiply; results arrive in order with no lost or duplicated outputs.
